// File: rtl/picorv32_wb_bridge_pkg.sv
// Shared types and constants for the picorv32 -> Wishbone pipelined bridge.
package picorv32_wb_bridge_pkg;

    localparam int          TIMER_W           = 16;
    localparam logic [3:0]  SEL_ALL           = 4'hF;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_t;

    // Every CPU-side and Wishbone-side output lives in this one registered bundle.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        ready;
        logic [31:0] rdata;
        logic        bus_err;
        logic [31:0] err_addr;
    } bridge_regs_t;

    localparam bridge_regs_t REGS_RESET = '0;

    // Reads fetch the whole word; writes select only the strobed bytes.
    function automatic logic [3:0] wb_sel(input logic [3:0] wstrb);
        return (|wstrb) ? wstrb : SEL_ALL;
    endfunction

endpackage

// File: rtl/picorv32_wb_bridge_if.sv
// Bundle of picorv32 native-memory and Wishbone signals seen by the bridge.
// The master modport is the bridge; the slave modport is the CPU plus the bus slaves.
interface picorv32_wb_bridge_if;

    logic        i_mem_valid;
    logic        i_mem_instr;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [3:0]  i_mem_wstrb;
    logic        o_mem_ready;
    logic [31:0] o_mem_rdata;

    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [31:0] i_wb_data;

    logic        o_bus_err;
    logic [31:0] o_err_addr;

    modport master (
        input  i_mem_valid, i_mem_instr, i_mem_addr, i_mem_wdata, i_mem_wstrb,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        output o_mem_ready, o_mem_rdata,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output o_bus_err, o_err_addr
    );

    modport slave (
        output i_mem_valid, i_mem_instr, i_mem_addr, i_mem_wdata, i_mem_wstrb,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data,
        input  o_mem_ready, o_mem_rdata,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  o_bus_err, o_err_addr
    );

endinterface

// File: rtl/picorv32_wb_bridge_bus_timeout.sv
// Saturating bus-transfer timeout counter, shared by the bus masters.
// o_expired is asserted once LIMIT enabled cycles have elapsed since the last clear.
module bus_timeout
    import picorv32_wb_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TIMER_W-1:0] LIMIT_W = TIMER_W'(LIMIT);

    logic [TIMER_W-1:0] count_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_enable && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign o_expired = (count_q >= LIMIT_W);

endmodule

// File: rtl/picorv32_wb_bridge.sv
// picorv32 native memory port to single-master Wishbone pipelined bridge.
// One Wishbone transaction per CPU request, ended by ack, err or a bounded timeout.
module picorv32_wb_bridge
    import picorv32_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    picorv32_wb_bridge_if.master bus
);

    bridge_state_t state_q, state_d;
    bridge_regs_t  regs_q, regs_d;
    logic          expired;

    // Fetch and data accesses are signalled identically on the bus.
    logic unused_instr;
    assign unused_instr = bus.i_mem_instr;

    bus_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (state_q == ST_IDLE),
        .i_enable ((state_q == ST_REQ) || (state_q == ST_WAIT)),
        .o_expired(expired)
    );

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        regs_d          = regs_q;
        regs_d.ready    = 1'b0;
        regs_d.bus_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_mem_valid) begin
                    state_d     = ST_REQ;
                    regs_d.cyc  = 1'b1;
                    regs_d.stb  = 1'b1;
                    regs_d.we   = |bus.i_mem_wstrb;
                    regs_d.addr = bus.i_mem_addr;
                    regs_d.data = bus.i_mem_wdata;
                    regs_d.sel  = wb_sel(bus.i_mem_wstrb);
                end
            end

            ST_REQ, ST_WAIT: begin
                if (bus.i_wb_err || bus.i_wb_ack || expired) begin
                    state_d      = ST_DONE;
                    regs_d.cyc   = 1'b0;
                    regs_d.stb   = 1'b0;
                    regs_d.ready = 1'b1;
                    // err outranks ack; a timeout is only reached with neither present.
                    if (bus.i_wb_err || !bus.i_wb_ack) begin
                        regs_d.rdata    = ERR_RDATA;
                        regs_d.bus_err  = 1'b1;
                        regs_d.err_addr = regs_q.addr;
                    end else if (!regs_q.we) begin
                        regs_d.rdata = bus.i_wb_data;
                    end
                end else if ((state_q == ST_REQ) && !bus.i_wb_stall) begin
                    state_d    = ST_WAIT;
                    regs_d.stb = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            regs_q  <= REGS_RESET;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.o_wb_cyc    = regs_q.cyc;
    assign bus.o_wb_stb    = regs_q.stb;
    assign bus.o_wb_we     = regs_q.we;
    assign bus.o_wb_addr   = regs_q.addr;
    assign bus.o_wb_data   = regs_q.data;
    assign bus.o_wb_sel    = regs_q.sel;
    assign bus.o_mem_ready = regs_q.ready;
    assign bus.o_mem_rdata = regs_q.rdata;
    assign bus.o_bus_err   = regs_q.bus_err;
    assign bus.o_err_addr  = regs_q.err_addr;

endmodule

// File: tb/tb_picorv32_wb_bridge.sv
// Directed bench for picorv32_wb_bridge: a configurable Wishbone slave plus a countdown timer model.
module tb_picorv32_wb_bridge;

    logic i_clk = 1'b0;
    logic i_reset;

    picorv32_wb_bridge_if bus ();

    picorv32_wb_bridge #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum {RSP_ACK, RSP_ERR, RSP_BOTH, RSP_NONE} rsp_t;
    rsp_t        cfg_rsp   = RSP_ACK;
    int          cfg_stall = 0;
    int          cfg_wait  = 0;
    logic [31:0] cfg_rdata = '0;
    int          slv_n     = 0;
    logic [31:0] timer     = '0;

    // Slave responds on the falling edge so its outputs look combinational to the DUT.
    // Cycle index slv_n counts from the first cyc cycle; the response lands at stall+wait.
    always @(negedge i_clk) begin
        if (i_reset || !bus.o_wb_cyc) begin
            slv_n          = 0;
            bus.i_wb_stall = 1'b0;
            bus.i_wb_ack   = 1'b0;
            bus.i_wb_err   = 1'b0;
            bus.i_wb_data  = '0;
        end else begin
            bus.i_wb_stall = bus.o_wb_stb && (slv_n < cfg_stall);
            bus.i_wb_ack   = (slv_n == cfg_stall + cfg_wait) && (cfg_rsp == RSP_ACK || cfg_rsp == RSP_BOTH);
            bus.i_wb_err   = (slv_n == cfg_stall + cfg_wait) && (cfg_rsp == RSP_ERR || cfg_rsp == RSP_BOTH);
            bus.i_wb_data  = (slv_n == cfg_stall + cfg_wait) ? cfg_rdata : 32'h0;
            slv_n++;
        end
    end

    // Countdown timer peripheral at 0x8000_0000.
    always @(posedge i_clk) begin
        if (bus.o_wb_cyc && bus.i_wb_ack && !bus.i_wb_err && bus.o_wb_we && bus.o_wb_addr == 32'h8000_0000)
            timer <= bus.o_wb_data;
        else if (timer != 0)
            timer <= timer - 1;
    end

    // Issues one CPU request and records what the bus and CPU side showed.
    // lat counts cycles from the valid-sampling cycle to the ready cycle (-1 if never).
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic instr, output int lat, output int stb_cycles,
                           output logic [31:0] rdata, output int err_pulses, output logic addr_stable,
                           output logic we_seen, output logic [3:0] sel_seen, output logic [31:0] addr_seen,
                           output logic [31:0] data_seen, output logic reissued);
        bit done = 0;
        lat = 0; stb_cycles = 0; rdata = '0; err_pulses = 0; addr_stable = 1'b1;
        we_seen = 1'b0; sel_seen = '0; addr_seen = '0; data_seen = '0; reissued = 1'b0;
        @(negedge i_clk);
        bus.i_mem_valid = 1'b1;
        bus.i_mem_instr = instr;
        bus.i_mem_addr  = addr;
        bus.i_mem_wdata = wdata;
        bus.i_mem_wstrb = wstrb;
        while (!done && lat < 64) begin
            @(negedge i_clk);
            lat++;
            if (bus.o_wb_stb) begin
                if (stb_cycles == 0) begin
                    we_seen = bus.o_wb_we; sel_seen = bus.o_wb_sel;
                    addr_seen = bus.o_wb_addr; data_seen = bus.o_wb_data;
                end else if (bus.o_wb_addr !== addr_seen) begin
                    addr_stable = 1'b0;
                end
                stb_cycles++;
            end
            if (bus.o_bus_err) err_pulses++;
            if (bus.o_mem_ready) begin
                done  = 1;
                rdata = bus.o_mem_rdata;
            end
        end
        if (!done) lat = -1;
        // The CPU keeps valid up through the ready cycle and drops it afterwards.
        @(posedge i_clk);
        #1;
        bus.i_mem_valid = 1'b0;
        bus.i_mem_wstrb = '0;
        @(negedge i_clk);
        if (bus.o_bus_err) err_pulses++;
        reissued = bus.o_wb_cyc;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        n_cmp++;
        if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel,
             bus.o_mem_ready, bus.o_mem_rdata, bus.o_bus_err, bus.o_err_addr} !== 137'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: cyc=%b stb=%b we=%b addr=%h data=%h sel=%h ready=%b rdata=%h err=%b err_addr=%h, all required 0",
                     bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel,
                     bus.o_mem_ready, bus.o_mem_rdata, bus.o_bus_err, bus.o_err_addr);
        end
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        n_cmp++;
        if ({bus.o_wb_cyc, bus.o_mem_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: cyc=%b ready=%b, required 0 0", bus.o_wb_cyc, bus.o_mem_ready);
        end
    endtask

    task automatic test_write_timer();
        int lat, stbs, errs; logic [31:0] rd, a, d; logic stable, we, reis; logic [3:0] sel;
        cfg_rsp = RSP_ACK; cfg_stall = 0; cfg_wait = 0; cfg_rdata = '0;
        run_txn(32'h8000_0000, 32'h0000_0010, 4'hF, 1'b0, lat, stbs, rd, errs, stable, we, sel, a, d, reis);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d required 2", lat); end
        n_cmp++; if (stbs !== 1) begin n_bad++; $display("FAIL wr_stb_cycles: got %0d required 1", stbs); end
        n_cmp++; if ({we, sel} !== 5'b1_1111) begin n_bad++; $display("FAIL wr_we_sel: got we=%b sel=%h required we=1 sel=f", we, sel); end
        n_cmp++; if ({a, d} !== {32'h8000_0000, 32'h0000_0010}) begin n_bad++; $display("FAIL wr_addr_data: got %h/%h required 80000000/00000010", a, d); end
        n_cmp++; if (reis !== 1'b0) begin n_bad++; $display("FAIL wr_no_reissue: cyc=%b required 0", reis); end
        // Loaded with 0x10 as ready rose; one decrement has happened since.
        n_cmp++; if (timer !== 32'h0F) begin n_bad++; $display("FAIL timer_loaded: got %h required 0000000f", timer); end
        repeat (3) @(negedge i_clk);
        n_cmp++; if (timer !== 32'h0C) begin n_bad++; $display("FAIL timer_counting: got %h required 0000000c", timer); end
    endtask

    task automatic test_read_stall_wait();
        int lat, stbs, errs; logic [31:0] rd, a, d; logic stable, we, reis; logic [3:0] sel;
        cfg_rsp = RSP_ACK; cfg_stall = 2; cfg_wait = 3; cfg_rdata = 32'h1234_5678;
        run_txn(32'h2000_0010, 32'hFFFF_FFFF, 4'h0, 1'b1, lat, stbs, rd, errs, stable, we, sel, a, d, reis);
        n_cmp++; if (stbs !== 3) begin n_bad++; $display("FAIL rd_stb_cycles: got %0d required 3", stbs); end
        n_cmp++; if (stable !== 1'b1 || a !== 32'h2000_0010) begin n_bad++; $display("FAIL rd_addr_held: stable=%b addr=%h required 1/20000010", stable, a); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data: got %h required 12345678", rd); end
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL rd_latency: got %0d required 7", lat); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL rd_no_err: got %0d pulses required 0", errs); end
    endtask

    task automatic test_byte_sel();
        int lat, stbs, errs; logic [31:0] rd, a, d; logic stable, we, reis; logic [3:0] sel;
        cfg_rsp = RSP_ACK; cfg_stall = 0; cfg_wait = 0; cfg_rdata = 32'h0000_00AA;
        run_txn(32'h4000_0002, 32'h00AB_0000, 4'b0100, 1'b0, lat, stbs, rd, errs, stable, we, sel, a, d, reis);
        n_cmp++; if ({we, sel} !== 5'b1_0100) begin n_bad++; $display("FAIL byte_wr_sel: got we=%b sel=%b required we=1 sel=0100", we, sel); end
        n_cmp++; if (d !== 32'h00AB_0000) begin n_bad++; $display("FAIL byte_wr_data: got %h required 00ab0000", d); end
        run_txn(32'h4000_0000, 32'h0000_0000, 4'b0000, 1'b0, lat, stbs, rd, errs, stable, we, sel, a, d, reis);
        n_cmp++; if ({we, sel} !== 5'b0_1111) begin n_bad++; $display("FAIL rd_sel: got we=%b sel=%b required we=0 sel=1111", we, sel); end
        n_cmp++; if (rd !== 32'h0000_00AA) begin n_bad++; $display("FAIL rd_word: got %h required 000000aa", rd); end
    endtask

    task automatic test_timeout();
        int lat, stbs, errs; logic [31:0] rd, a, d; logic stable, we, reis; logic [3:0] sel;
        cfg_rsp = RSP_NONE; cfg_stall = 0; cfg_wait = 0; cfg_rdata = '0;
        run_txn(32'h9000_0004, 32'h0, 4'h0, 1'b0, lat, stbs, rd, errs, stable, we, sel, a, d, reis);
        // stb rises at cycle 1; ready 8+1 cycles later.
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL to_latency: got %0d required 10", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL to_rdata: got %h required deadbeef", rd); end
        n_cmp++; if (errs !== 1) begin n_bad++; $display("FAIL to_err_pulses: got %0d required 1", errs); end
        n_cmp++; if (bus.o_err_addr !== 32'h9000_0004) begin n_bad++; $display("FAIL to_err_addr: got %h required 90000004", bus.o_err_addr); end
    endtask

    task automatic test_ack_err_same_cycle();
        int lat, stbs, errs; logic [31:0] rd, a, d; logic stable, we, reis; logic [3:0] sel;
        cfg_rsp = RSP_BOTH; cfg_stall = 0; cfg_wait = 1; cfg_rdata = 32'h5555_5555;
        run_txn(32'h3000_0008, 32'h0, 4'h0, 1'b0, lat, stbs, rd, errs, stable, we, sel, a, d, reis);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL both_rdata: got %h required deadbeef", rd); end
        n_cmp++; if (errs !== 1) begin n_bad++; $display("FAIL both_err_pulses: got %0d required 1", errs); end
        n_cmp++; if (bus.o_err_addr !== 32'h3000_0008) begin n_bad++; $display("FAIL both_err_addr: got %h required 30000008", bus.o_err_addr); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL both_latency: got %0d required 3", lat); end
    endtask

    task automatic test_reset_in_wait();
        int lat, stbs, errs; logic [31:0] rd, a, d; logic stable, we, reis; logic [3:0] sel;
        cfg_rsp = RSP_NONE; cfg_stall = 0; cfg_wait = 0;
        @(negedge i_clk);
        bus.i_mem_valid = 1'b1; bus.i_mem_addr = 32'h5000_0000; bus.i_mem_wstrb = 4'h0;
        repeat (2) @(negedge i_clk);
        n_cmp++; if ({bus.o_wb_cyc, bus.o_wb_stb} !== 2'b10) begin n_bad++; $display("FAIL rst_in_wait_pre: cyc/stb=%b%b required 10", bus.o_wb_cyc, bus.o_wb_stb); end
        i_reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_mem_ready} !== 3'b000 || bus.o_err_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_async: cyc=%b stb=%b ready=%b err_addr=%h required 0 0 0 0", bus.o_wb_cyc, bus.o_wb_stb, bus.o_mem_ready, bus.o_err_addr);
        end
        bus.i_mem_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        cfg_rsp = RSP_ACK; cfg_rdata = 32'hCAFE_F00D;
        run_txn(32'h5000_0000, 32'h0, 4'h0, 1'b0, lat, stbs, rd, errs, stable, we, sel, a, d, reis);
        n_cmp++; if (lat !== 2 || rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL post_rst_read: lat=%0d rdata=%h required 2/cafef00d", lat, rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        i_reset         = 1'b1;
        bus.i_mem_valid = 1'b0;
        bus.i_mem_instr = 1'b0;
        bus.i_mem_addr  = '0;
        bus.i_mem_wdata = '0;
        bus.i_mem_wstrb = '0;
        bus.i_wb_stall  = 1'b0;
        bus.i_wb_ack    = 1'b0;
        bus.i_wb_err    = 1'b0;
        bus.i_wb_data   = '0;
        test_reset();
        test_write_timer();
        test_read_stall_wait();
        test_byte_sel();
        test_timeout();
        test_ack_err_same_cycle();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/picorv32_wb_bridge.md
# picorv32_wb_bridge

Bridges the picorv32 native memory interface to a single-master Wishbone pipelined bus. It sits directly upstream of the peripheral slaves, including the countdown timer, and converts each `mem_valid` request into exactly one Wishbone transaction. A bounded timeout ensures a missing or failed slave ends the transfer with an error instead of hanging the CPU.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed from `o_wb_stb` rising to ack/err before abort; valid range 1–65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: value returned on `o_mem_rdata` for an errored or timed-out read.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `i_clk`  in  1  sole clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_mem_valid`  in  1  CPU request valid.
- `i_mem_instr`  in  1  instruction fetch flag; informational only.
- `i_mem_addr`  in  32  byte address.
- `i_mem_wdata`  in  32  write data.
- `i_mem_wstrb`  in  4  byte strobes; 0 = read.
- `o_mem_ready`  out  1  one-cycle completion pulse.
- `o_mem_rdata`  out  32  read data, valid while `o_mem_ready`=1.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1 each  Wishbone control.
- `o_wb_addr`  out  32  Wishbone address.
- `o_wb_data`  out  32  Wishbone write data.
- `o_wb_sel`  out  4  Wishbone byte select.
- `i_wb_stall`, `i_wb_ack`, `i_wb_err`  in  1 each  slave response.
- `i_wb_data`  in  32  slave read data.
- `o_bus_err`  out  1  one-cycle pulse on err or timeout.
- `o_err_addr`  out  32  address of the most recent failed transfer; sticky.

## Operation
- FSM states:
  - IDLE: `i_mem_valid`=1 → REQ. Capture addr, wdata and strobes. Set `o_wb_we` = |`i_mem_wstrb`. Set `o_wb_sel` = `i_mem_wstrb` for a write, 4'hF for a read.
  - REQ: `o_wb_cyc`=`o_wb_stb`=1, all fields held. `i_wb_stall`=0 → WAIT, unless ack/err is present in the same cycle.
  - WAIT: `o_wb_cyc`=1, `o_wb_stb`=0.
  - DONE: `o_mem_ready`=1 for exactly one cycle, then IDLE.
- Completion, checked in both REQ and WAIT, in priority order:
  - `i_wb_err` → DONE with error. `o_mem_rdata`=`ERR_RDATA`, `o_bus_err` pulses, `o_err_addr` is updated.
  - `i_wb_ack` → DONE. On a read, `o_mem_rdata` is registered from `i_wb_data`.
  - Timeout counter reaches `TIMEOUT_CYCLES` → DONE with error, treated the same as `i_wb_err`.
- Entering DONE drops `o_wb_cyc` and `o_wb_stb` in the same registered update.
- The timeout counter is 16 bits. It clears in IDLE, increments in REQ/WAIT, and saturates; it never wraps.
- Exactly one Wishbone transaction per CPU request; no pipelining of multiple requests.
- `i_mem_valid` is ignored outside IDLE.
- `i_mem_instr` has no effect on Wishbone signalling.
- A simultaneous ack and err resolves as err.

## Timing
- Every Wishbone and CPU-side output is registered.
- Reset values:
  - state IDLE.
  - `o_wb_cyc`=`o_wb_stb`=`o_wb_we`=0.
  - `o_wb_addr`=0, `o_wb_data`=0, `o_wb_sel`=0.
  - `o_mem_ready`=0, `o_mem_rdata`=0.
  - `o_bus_err`=0, `o_err_addr`=0.
- Zero-wait slave (combinational ack, stall=0):
  - cycle 0: `i_mem_valid` sampled.
  - cycle 1: `o_wb_stb`=1; ack arrives in the same cycle.
  - cycle 2: `o_mem_ready`=1.
  - Total: 2 cycles valid→ready.
- Each stall cycle and each WAIT cycle adds 1 cycle.
- Timeout with no response: `o_mem_ready` fires `TIMEOUT_CYCLES`+1 cycles after `o_wb_stb` first rises.
- picorv32 drops `i_mem_valid` the cycle after `o_mem_ready`. Because DONE→IDLE takes one cycle, no transaction is re-issued.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous); the in-flight transaction is abandoned.

## Structure
- Shared include `picorv32_wb_defs.vh` holds:
  - state encodings `ST_IDLE`/`ST_REQ`/`ST_WAIT`/`ST_DONE` (2-bit).
  - `ERR_RDATA` default value.
  - `SEL_ALL` = 4'hF.
- One sub-module, `bus_timeout`: a saturating counter with inputs clear and enable, `LIMIT` parameter, output `expired`. It is reused later by other bus masters.
- Target 150–250 lines of RTL total.

## Test plan
- Write, combinational-ack slave (timer model), addr 0x8000_0000, wdata 0x0000_0010, wstrb 4'hF → one cycle of stb=1/we=1/sel=4'hF; ack; `o_mem_ready` 2 cycles after valid; timer then counts down from 0x10.
- Read, slave with 2 stall + 3 wait cycles, `i_wb_data`=0x1234_5678 → stb held 3 cycles with constant addr; `o_mem_rdata`=0x1234_5678; ready at cycle 7.
- Byte write with wstrb 4'b0100 → `o_wb_sel`=4'b0100, `o_wb_we`=1; read with wstrb 0 → `o_wb_sel`=4'hF, `o_wb_we`=0.
- No slave response, `TIMEOUT_CYCLES`=8, read of 0x9000_0004 → ready 9 cycles after stb; rdata=0xDEAD_BEEF; `o_bus_err` pulses once; `o_err_addr`=0x9000_0004.
- Ack and err in the same cycle → error path taken. `i_reset` asserted during WAIT → cyc/stb/ready low in the same cycle; after release, next request completes normally.
